// File: rtl/msi_snooper.sv
// Snoop-side half of an MSI coherence controller: holds per-line MSI state and tag,
// reacts to broadcast bus messages, and requests writebacks for Modified lines.
module msi_snooper #(
  parameter int LINES = 4,
  parameter int IDX_W = 2,
  parameter int TAG_W = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   bus_valid,
  input  logic [1:0]             bus_msg,
  input  logic [TAG_W+IDX_W-1:0] bus_addr,
  output logic                   bus_ready,
  output logic                   snoop_done,
  output logic                   snoop_hit,
  output logic                   abort_access,
  output logic                   protocol_err,
  output logic                   wb_req,
  output logic [TAG_W+IDX_W-1:0] wb_addr,
  input  logic                   wb_ack,
  input  logic                   upd_en,
  input  logic [IDX_W-1:0]       upd_idx,
  input  logic [TAG_W-1:0]       upd_tag,
  input  logic [1:0]             upd_status,
  input  logic [IDX_W-1:0]       rd_idx,
  output logic [1:0]             rd_status
);

  localparam int AW = TAG_W + IDX_W;

  typedef enum logic [1:0] {FSM_IDLE, FSM_EVAL, FSM_WB, FSM_RESP} fsm_t;
  typedef enum logic [1:0] {
    MSG_WRITE_MISS = 2'b00, MSG_READ_MISS = 2'b01, MSG_INVALIDATE = 2'b10, MSG_NA = 2'b11
  } msg_t;
  typedef enum logic [1:0] {LN_I = 2'b00, LN_S = 2'b01, LN_M = 2'b10, LN_RSV = 2'b11} line_t;

  fsm_t             fsm_q, fsm_d;
  msg_t             msg_q, msg_d;
  logic [AW-1:0]    addr_q, addr_d;
  line_t            st_q [LINES];
  line_t            st_d [LINES];
  logic [TAG_W-1:0] tag_q [LINES];
  logic [TAG_W-1:0] tag_d [LINES];
  logic             wb_req_q, wb_req_d;
  logic [AW-1:0]    wb_addr_q, wb_addr_d;
  logic             done_q, done_d;
  logic             hit_q, hit_d;
  logic             abort_q, abort_d;
  logic             perr_q, perr_d;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  line_t            cur_st;
  logic             tag_hit;
  logic             snp_we;
  line_t            snp_st;

  assign idx     = addr_q[IDX_W-1:0];
  assign tag     = addr_q[AW-1:IDX_W];
  assign cur_st  = st_q[idx];
  assign tag_hit = (tag_q[idx] == tag) && (cur_st != LN_I);

  always_comb begin
    fsm_d     = fsm_q;
    msg_d     = msg_q;
    addr_d    = addr_q;
    st_d      = st_q;
    tag_d     = tag_q;
    wb_req_d  = wb_req_q;
    wb_addr_d = wb_addr_q;
    done_d    = 1'b0;
    hit_d     = 1'b0;
    abort_d   = 1'b0;
    perr_d    = 1'b0;
    snp_we    = 1'b0;
    snp_st    = LN_I;

    if (upd_en && upd_status != 2'b11) begin
      st_d[upd_idx]  = line_t'(upd_status);
      tag_d[upd_idx] = upd_tag;
    end

    unique case (fsm_q)
      FSM_IDLE: begin
        if (bus_valid) begin
          msg_d  = msg_t'(bus_msg);
          addr_d = bus_addr;
          fsm_d  = FSM_EVAL;
        end
      end
      FSM_EVAL: begin
        fsm_d  = FSM_RESP;
        done_d = 1'b1;
        hit_d  = tag_hit;
        if (tag_hit && cur_st == LN_S &&
            (msg_q == MSG_WRITE_MISS || msg_q == MSG_INVALIDATE)) begin
          snp_we = 1'b1;
          snp_st = LN_I;
        end
        if (tag_hit && cur_st == LN_M) begin
          if (msg_q == MSG_WRITE_MISS || msg_q == MSG_READ_MISS) begin
            // Response flags are raised later, when the writeback completes.
            fsm_d     = FSM_WB;
            wb_req_d  = 1'b1;
            wb_addr_d = {tag_q[idx], idx};
            done_d    = 1'b0;
            hit_d     = 1'b0;
          end else if (msg_q == MSG_INVALIDATE) begin
            perr_d = 1'b1;
          end
        end
      end
      FSM_WB: begin
        if (wb_ack) begin
          wb_req_d = 1'b0;
          snp_we   = 1'b1;
          snp_st   = (msg_q == MSG_READ_MISS) ? LN_S : LN_I;
          fsm_d    = FSM_RESP;
          done_d   = 1'b1;
          hit_d    = 1'b1;
          abort_d  = 1'b1;
        end
      end
      FSM_RESP: fsm_d = FSM_IDLE;
    endcase

    // A snoop write to the same line overrides a coincident local update entirely.
    if (snp_we) begin
      st_d[idx]  = snp_st;
      tag_d[idx] = tag_q[idx];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q     <= FSM_IDLE;
      msg_q     <= MSG_WRITE_MISS;
      addr_q    <= '0;
      for (int unsigned i = 0; i < LINES; i++) begin
        st_q[i]  <= LN_I;
        tag_q[i] <= '0;
      end
      wb_req_q  <= 1'b0;
      wb_addr_q <= '0;
      done_q    <= 1'b0;
      hit_q     <= 1'b0;
      abort_q   <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      msg_q     <= msg_d;
      addr_q    <= addr_d;
      st_q      <= st_d;
      tag_q     <= tag_d;
      wb_req_q  <= wb_req_d;
      wb_addr_q <= wb_addr_d;
      done_q    <= done_d;
      hit_q     <= hit_d;
      abort_q   <= abort_d;
      perr_q    <= perr_d;
    end
  end

  assign bus_ready    = (fsm_q == FSM_IDLE);
  assign snoop_done   = done_q;
  assign snoop_hit    = hit_q;
  assign abort_access = abort_q;
  assign protocol_err = perr_q;
  assign wb_req       = wb_req_q;
  assign wb_addr      = wb_addr_q;
  assign rd_status    = st_q[rd_idx];

endmodule

// File: tb/tb_msi_snooper.sv
// Self-checking bench for msi_snooper: directed scenarios plus random bus traffic
// checked against an array-based MSI model.
module tb_msi_snooper;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       bus_valid;
  logic [1:0] bus_msg;
  logic [9:0] bus_addr;
  logic       bus_ready, snoop_done, snoop_hit, abort_access, protocol_err, wb_req;
  logic [9:0] wb_addr;
  logic       wb_ack;
  logic       upd_en;
  logic [1:0] upd_idx;
  logic [7:0] upd_tag;
  logic [1:0] upd_status;
  logic [1:0] rd_idx;
  logic [1:0] rd_status;

  int n_checks = 0;
  int n_fail   = 0;
  int m_st  [4];
  int m_tag [4];

  msi_snooper #(.LINES(4), .IDX_W(2), .TAG_W(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .bus_valid(bus_valid), .bus_msg(bus_msg), .bus_addr(bus_addr), .bus_ready(bus_ready),
    .snoop_done(snoop_done), .snoop_hit(snoop_hit), .abort_access(abort_access),
    .protocol_err(protocol_err), .wb_req(wb_req), .wb_addr(wb_addr), .wb_ack(wb_ack),
    .upd_en(upd_en), .upd_idx(upd_idx), .upd_tag(upd_tag), .upd_status(upd_status),
    .rd_idx(rd_idx), .rd_status(rd_status)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_st[i]  = 0;
      m_tag[i] = 0;
    end
  endtask

  task automatic model_upd(input int i, input int t, input int s);
    if (s != 3) begin
      m_st[i]  = s;
      m_tag[i] = t;
    end
  endtask

  task automatic check_lines(input string name);
    for (int i = 0; i < 4; i++) begin
      rd_idx = 2'(i);
      #1;
      n_checks++;
      if (rd_status !== 2'(m_st[i])) begin
        n_fail++;
        $display("FAIL %s.line%0d rd_status got %0d expected %0d", name, i, rd_status, m_st[i]);
      end
    end
  endtask

  task automatic upd_line(input int i, input int t, input int s);
    upd_en = 1'b1; upd_idx = 2'(i); upd_tag = 8'(t); upd_status = 2'(s);
    tick();
    upd_en = 1'b0;
    model_upd(i, t, s);
  endtask

  // One bus transaction from accept to return-to-idle; optional local updates on the
  // accept edge (u0) and on the wb_ack edge (ua).
  task automatic do_txn(input string name, input int msg, input int tg, input int i,
                        input int ack_dly,
                        input bit u0_en, input int u0_idx, input int u0_tag, input int u0_st,
                        input bit ua_en, input int ua_idx, input int ua_tag, input int ua_st);
    int old_st, new_st;
    bit hit, exp_wb, exp_perr;
    n_checks++;
    if (bus_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s.ready_idle got %b expected 1", name, bus_ready);
    end
    bus_valid = 1'b1; bus_msg = 2'(msg); bus_addr = {8'(tg), 2'(i)};
    if (u0_en) begin
      upd_en = 1'b1; upd_idx = 2'(u0_idx); upd_tag = 8'(u0_tag); upd_status = 2'(u0_st);
    end
    tick();
    bus_valid = 1'b0; upd_en = 1'b0;
    if (u0_en) model_upd(u0_idx, u0_tag, u0_st);

    old_st   = m_st[i];
    hit      = (m_tag[i] == tg) && (old_st != 0);
    exp_wb   = hit && old_st == 2 && (msg == 0 || msg == 1);
    exp_perr = hit && old_st == 2 && msg == 2;
    new_st   = old_st;
    if (hit && old_st == 1 && (msg == 0 || msg == 2)) new_st = 0;
    if (exp_wb) new_st = (msg == 1) ? 1 : 0;

    n_checks++;
    if (bus_ready !== 1'b0 || snoop_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s.eval_busy got ready=%b done=%b expected ready=0 done=0", name, bus_ready, snoop_done);
    end
    tick();
    if (exp_wb) begin
      n_checks++;
      if (wb_req !== 1'b1 || wb_addr !== {8'(tg), 2'(i)} || snoop_done !== 1'b0) begin
        n_fail++;
        $display("FAIL %s.wb_start got req=%b addr=%h done=%b expected req=1 addr=%h done=0",
                 name, wb_req, wb_addr, snoop_done, {8'(tg), 2'(i)});
      end
      repeat (ack_dly) tick();
      n_checks++;
      if (wb_req !== 1'b1 || snoop_done !== 1'b0) begin
        n_fail++; $display("FAIL %s.wb_hold got req=%b done=%b expected req=1 done=0", name, wb_req, snoop_done);
      end
      wb_ack = 1'b1;
      if (ua_en) begin
        upd_en = 1'b1; upd_idx = 2'(ua_idx); upd_tag = 8'(ua_tag); upd_status = 2'(ua_st);
      end
      tick();
      wb_ack = 1'b0; upd_en = 1'b0;
      if (ua_en && ua_idx != i) model_upd(ua_idx, ua_tag, ua_st);
    end
    m_st[i] = new_st;

    n_checks++;
    if (snoop_done !== 1'b1 || snoop_hit !== hit || abort_access !== exp_wb ||
        protocol_err !== exp_perr || wb_req !== 1'b0) begin
      n_fail++;
      $display("FAIL %s.resp got done=%b hit=%b abort=%b perr=%b wbreq=%b expected 1 %b %b %b 0",
               name, snoop_done, snoop_hit, abort_access, protocol_err, wb_req, hit, exp_wb, exp_perr);
    end
    tick();
    n_checks++;
    if (snoop_done !== 1'b0 || snoop_hit !== 1'b0 || abort_access !== 1'b0 ||
        protocol_err !== 1'b0 || bus_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s.after got done=%b hit=%b abort=%b perr=%b ready=%b expected 0 0 0 0 1",
               name, snoop_done, snoop_hit, abort_access, protocol_err, bus_ready);
    end
    check_lines(name);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (bus_ready !== 1'b1 || wb_req !== 1'b0 || snoop_done !== 1'b0 || snoop_hit !== 1'b0 ||
        abort_access !== 1'b0 || protocol_err !== 1'b0 || wb_addr !== 10'h000) begin
      n_fail++;
      $display("FAIL reset.outputs got ready=%b wbreq=%b done=%b hit=%b abort=%b perr=%b wbaddr=%h expected 1 0 0 0 0 0 000",
               bus_ready, wb_req, snoop_done, snoop_hit, abort_access, protocol_err, wb_addr);
    end
    check_lines("reset");
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_read_miss_shared();
    upd_line(1, 8'h3A, 1);
    do_txn("rm_shared", 1, 8'h3A, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_write_miss_modified();
    upd_line(2, 8'h55, 2);
    do_txn("wm_modified", 0, 8'h55, 2, 5, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_invalidate();
    upd_line(0, 8'h10, 1);
    do_txn("inv_tagmiss", 2, 8'h11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_txn("inv_taghit", 2, 8'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_protocol_err();
    upd_line(3, 8'h7F, 2);
    do_txn("inv_modified", 2, 8'h7F, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_upd_collision();
    upd_line(1, 8'h20, 2);
    do_txn("collide_ack", 1, 8'h20, 1, 3, 0, 0, 0, 0, 1, 1, 8'h99, 2);
    do_txn("accept_upd", 1, 8'h44, 2, 1, 1, 2, 8'h44, 2, 1, 3, 8'h66, 1);
  endtask

  task automatic test_stray_ack();
    wb_ack = 1'b1;
    tick();
    tick();
    n_checks++;
    if (wb_req !== 1'b0 || snoop_done !== 1'b0 || bus_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stray_ack got wbreq=%b done=%b ready=%b expected 0 0 1", wb_req, snoop_done, bus_ready);
    end
    wb_ack = 1'b0;
    check_lines("stray_ack");
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(1, 0) == 1)
        upd_line(int'($urandom_range(3, 0)), 8'h10 + int'($urandom_range(1, 0)), int'($urandom_range(3, 0)));
      do_txn("random", int'($urandom_range(3, 0)), 8'h10 + int'($urandom_range(1, 0)),
             int'($urandom_range(3, 0)), int'($urandom_range(4, 0)),
             1'($urandom_range(1, 0)), int'($urandom_range(3, 0)), 8'h10 + int'($urandom_range(1, 0)),
             int'($urandom_range(3, 0)),
             1'($urandom_range(1, 0)), int'($urandom_range(3, 0)), 8'h10 + int'($urandom_range(1, 0)),
             int'($urandom_range(3, 0)));
    end
  endtask

  task automatic test_reset_mid_wb();
    upd_line(2, 8'h55, 2);
    bus_valid = 1'b1; bus_msg = 2'b00; bus_addr = {8'h55, 2'd2};
    tick();
    bus_valid = 1'b0;
    tick();
    tick();
    n_checks++;
    if (wb_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_wb.pending got wbreq=%b expected 1", wb_req);
    end
    #1;
    reset_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (wb_req !== 1'b0 || wb_addr !== 10'h000 || snoop_done !== 1'b0 || bus_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_wb.outputs got wbreq=%b wbaddr=%h done=%b ready=%b expected 0 000 0 1",
               wb_req, wb_addr, snoop_done, bus_ready);
    end
    check_lines("rst_wb");
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    bus_valid = 1'b0; bus_msg = 2'b00; bus_addr = '0; wb_ack = 1'b0;
    upd_en = 1'b0; upd_idx = '0; upd_tag = '0; upd_status = '0; rd_idx = '0;
    test_reset();
    test_read_miss_shared();
    test_write_miss_modified();
    test_invalidate();
    test_protocol_err();
    test_upd_collision();
    test_stray_ack();
    test_random();
    test_reset_mid_wb();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
